operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Downstream neighbour of the address generator. Takes its paired A/B read addresses, issues
//  reads to the A and B operand SRAMs, and realigns the returned 32-bit words by datatype. It
//  then buffers the aligned A/B operand pairs in a shallow FIFO that feeds the systolic array
//  edge with valid/ready. It also turns the generator's compute-mode strobe into a drain/done
//  sequence.
// PARAMETERS
//  AW        10  SRAM word-address width; sram_addr_x = rdaddr_x[AW:1] (bit 0 = sub-word select)
//  SRAM_LAT  1   cycles from sram_re to valid sram_rdata (1..3)
//  DEPTH     4   output FIFO entries (power of two, >= SRAM_LAT+1)
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous reset, active-high
//  datatype      in   dtype  params::dtype_t (FP32/FP16/INT8/INT4), sampled per request
//  en_in         in   1      request strobe: one A+B address pair this cycle
//  rdaddr_A      in   32     A address from address generator
//  rdaddr_B      in   32     B address from address generator
//  cm_in         in   1      compute-mode strobe: start drain
//  req_ready     out  1      a request would be accepted this cycle
//  sram_re_A     out  1      A SRAM read enable
//  sram_addr_A   out  AW     A SRAM word address
//  sram_rdata_A  in   32     A SRAM read data
//  sram_re_B     out  1      B SRAM read enable
//  sram_addr_B   out  AW     B SRAM word address
//  sram_rdata_B  in   32     B SRAM read data
//  op_valid      out  1      aligned pair available
//  op_ready      in   1      array accepts pair
//  op_a          out  32     aligned A operand
//  op_b          out  32     aligned B operand
//  done          out  1      one-cycle pulse: drain complete
//  err           out  1      sticky protocol error
//  stall_cnt     out  32     (OPF_PERF_EN only) cycles with op_valid & !op_ready
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; in-flight count 0; state RUN; err cleared.
//  - Credit: req_ready = (inflight + fifo_count) < DEPTH. Accept = en_in & req_ready & state==RUN.
//  - Accept: sram_re_A/B=1 the same cycle (combinational from en_in), sram_addr_x=rdaddr_x[AW:1].
//    A tag {datatype, rdaddr_A[0], rdaddr_B[0]} enters a SRAM_LAT-deep shift pipe.
//  - SRAM_LAT cycles later: data aligned and pushed to FIFO; inflight decrements that cycle.
//    The credit scheme guarantees the push never overflows.
//  - Alignment, per lane, sel = stored addr bit 0:
//    FP32: word unchanged. FP16: sel?w[31:16]:w[15:0], zero-extended to 32.
//    INT8/INT4: word unchanged (packed lanes, unpacked in PE).
//  - Output: op_valid = !fifo_empty; pop on op_valid & op_ready; FWFT, data stable while stalled.
//    Push and pop in the same cycle keep fifo_count unchanged. Pop on the full FIFO is legal.
//  - en_in while !req_ready or state!=RUN: request dropped, no SRAM read, err<=1.
//  - FSM RUN -> DRAIN on cm_in. Also on cm_in&en_in in the same cycle: the request is accepted
//    first, then the FSM enters DRAIN.
//  - DRAIN -> DONE when inflight==0 and the FIFO is empty (the last pop seen).
//  - DONE: done=1 for one cycle, then RUN. cm_in during DRAIN/DONE is ignored, err unchanged.
//  - Reset mid-operation discards in-flight tags and FIFO contents; late sram_rdata is ignored.
//  - Pointer and count widths are $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
// CONFIGURATION
//  OPF_PERF_EN defined: stall_cnt port exists. It counts op_valid & !op_ready cycles,
//    saturates at 32'hFFFF_FFFF, and is cleared by rst.
//  OPF_PERF_EN undefined: no port, no counter logic.
// STRUCTURE
//  params package: dtype_t enum (FP32/FP16/INT8/INT4); opf_tag_t struct {dtype_t dt; logic sel_a, sel_b}.
//  Sub-module opf_lane_align: combinational 32-bit align from (dt, sel, word), instanced for A and B.
//  FIFO, credit counter, tag pipe and FSM are local to operand_fetch.
// TESTING
//  1 FP32, SRAM_LAT=1, op_ready=1, 8 back-to-back en_in, rdaddr=2k -> sram_addr=k.
//    8 pairs out in order, first op_valid 2 cycles after first en_in.
//  2 FP16, rdaddr_A=5, rdaddr_A=4, word 32'hBEEF_CAFE
//    -> op_a=32'h0000_BEEF for address 5, then 32'h0000_CAFE for address 4.
//  3 op_ready=0, en_in held 6 cycles -> req_ready drops after 4 accepts.
//    5th/6th requests dropped, err=1. Release op_ready -> 4 pairs, no loss, no overflow.
//  4 cm_in with 3 pairs outstanding, op_ready toggling 1/0
//    -> done pulses once, exactly the cycle after the final pop. en_in during DRAIN sets err.
//  5 rst asserted with 2 reads in flight, then 1 en_in -> only the post-reset pair emerges.
//    All outputs are 0 in the reset cycle.
//  6 OPF_PERF_EN: 10 stalled cycles -> stall_cnt=10; without macro the build elaborates without stall_cnt.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch stage: datatype encoding, the per-request tag
// carried alongside SRAM reads, and the drain sequencer states.
package params;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } dtype_t;

  typedef struct packed {
    dtype_t dt;
    logic   sel_a;
    logic   sel_b;
  } opf_tag_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } opf_state_t;

endpackage

// File: rtl/operand_fetch_lane_align.sv
// Combinational realignment of one returned 32-bit SRAM word according to datatype
// and the sub-word select captured with the request.
module opf_lane_align
  import params::*;
(
  input  dtype_t      dt,
  input  logic        sel,
  input  logic [31:0] word,
  output logic [31:0] aligned
);

  // Only FP16 picks a half-word; packed integer lanes are unpacked in the PE.
  always_comb begin
    aligned = word;
    if (dt == FP16) aligned = sel ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: issues paired A/B SRAM reads, aligns the returned words, buffers pairs
// in a credit-protected FWFT FIFO and sequences drain/done. OPF_PERF_EN adds stall_cnt.
module operand_fetch
  import params::*;
#(
  parameter int AW       = 10,
  parameter int SRAM_LAT = 1,
  parameter int DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  dtype_t        datatype,
  input  logic          en_in,
  input  logic [31:0]   rdaddr_A,
  input  logic [31:0]   rdaddr_B,
  input  logic          cm_in,
  output logic          req_ready,
  output logic          sram_re_A,
  output logic [AW-1:0] sram_addr_A,
  input  logic [31:0]   sram_rdata_A,
  output logic          sram_re_B,
  output logic [AW-1:0] sram_addr_B,
  input  logic [31:0]   sram_rdata_B,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [31:0]   op_a,
  output logic [31:0]   op_b,
  output logic          done,
  output logic          err
`ifdef OPF_PERF_EN
  ,output logic [31:0]  stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int CW = PW + 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  opf_state_t        state, state_nxt;
  logic [PW-1:0]     inflight, inflight_nxt;
  logic [PW-1:0]     fifo_count, count_nxt;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     credit;
  logic              run, accept, push, pop, done_c, err_q;
  opf_tag_t          tag_p [SRAM_LAT];
  logic [SRAM_LAT-1:0] vld_p;
  logic [31:0]       fifo_a [DEPTH];
  logic [31:0]       fifo_b [DEPTH];
  logic [31:0]       align_a, align_b;
  logic              unused_bits;

  assign unused_bits = ^{rdaddr_A[31:AW+1], rdaddr_B[31:AW+1], wr_ptr[PW-1], rd_ptr[PW-1]};

  // Request side: outputs are forced low while reset is asserted.
  assign credit      = {1'b0, inflight} + {1'b0, fifo_count};
  assign run         = (state == ST_RUN);
  assign req_ready   = !rst && (credit < CW'(DEPTH));
  assign accept      = en_in && req_ready && run;
  assign sram_re_A   = accept;
  assign sram_re_B   = accept;
  assign sram_addr_A = accept ? rdaddr_A[AW:1] : '0;
  assign sram_addr_B = accept ? rdaddr_B[AW:1] : '0;

  assign push         = vld_p[SRAM_LAT-1];
  assign op_valid     = !rst && (fifo_count != '0);
  assign pop          = op_valid && op_ready;
  assign op_a         = op_valid ? fifo_a[rd_ptr[PW-2:0]] : '0;
  assign op_b         = op_valid ? fifo_b[rd_ptr[PW-2:0]] : '0;
  assign inflight_nxt = inflight + PW'(accept) - PW'(push);
  assign count_nxt    = fifo_count + PW'(push) - PW'(pop);
  assign done         = done_c && !rst;
  assign err          = err_q && !rst;

  // Stage p0..pN: tag pipe matching SRAM read latency
  always_ff @(posedge clk) begin
    if (rst) vld_p <= '0;
    else begin
      vld_p[0] <= accept;
      for (int i = 1; i < SRAM_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= '{dt: datatype, sel_a: rdaddr_A[0], sel_b: rdaddr_B[0]};
    for (int i = 1; i < SRAM_LAT; i++) tag_p[i] <= tag_p[i-1];
  end

  opf_lane_align u_align_a (
    .dt(tag_p[SRAM_LAT-1].dt), .sel(tag_p[SRAM_LAT-1].sel_a),
    .word(sram_rdata_A), .aligned(align_a)
  );
  opf_lane_align u_align_b (
    .dt(tag_p[SRAM_LAT-1].dt), .sel(tag_p[SRAM_LAT-1].sel_b),
    .word(sram_rdata_B), .aligned(align_b)
  );

  // Output FIFO stage: storage is not reset, occupancy is
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr[PW-2:0]] <= align_a;
      fifo_b[wr_ptr[PW-2:0]] <= align_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight   <= inflight_nxt;
      fifo_count <= count_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (en_in && !accept) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Drain completes on the cycle whose pop empties everything, so done follows it directly.
  always_comb begin
    state_nxt = state;
    done_c    = 1'b0;
    case (state)
      ST_RUN:   if (cm_in) state_nxt = ST_DRAIN;
      ST_DRAIN: if (inflight_nxt == '0 && count_nxt == '0) state_nxt = ST_DONE;
      ST_DONE: begin
        done_c    = 1'b1;
        state_nxt = ST_RUN;
      end
      default:  state_nxt = ST_RUN;
    endcase
  end

`ifdef OPF_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else if (op_valid && !op_ready) stall_q <= sat_inc(stall_q);
  end

  assign stall_cnt = rst ? '0 : stall_q;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: alignment vector table, directed multi-cycle
// sequences and randomized traffic against a transaction-level reference model.
module tb_operand_fetch;
  import params::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, en_in, cm_in, op_ready;
  dtype_t      datatype;
  logic [31:0] rdaddr_A, rdaddr_B, sram_rdata_A, sram_rdata_B, op_a, op_b;
  logic        req_ready, sram_re_A, sram_re_B, op_valid, done, err;
  logic [9:0]  sram_addr_A, sram_addr_B;
`ifdef OPF_PERF_EN
  logic [31:0] stall_cnt;
`endif

  operand_fetch dut (
    .clk(clk), .rst(rst), .datatype(datatype), .en_in(en_in),
    .rdaddr_A(rdaddr_A), .rdaddr_B(rdaddr_B), .cm_in(cm_in), .req_ready(req_ready),
    .sram_re_A(sram_re_A), .sram_addr_A(sram_addr_A), .sram_rdata_A(sram_rdata_A),
    .sram_re_B(sram_re_B), .sram_addr_B(sram_addr_B), .sram_rdata_B(sram_rdata_B),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .done(done), .err(err)
`ifdef OPF_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem_a_tb [1024];
  logic [31:0] mem_b_tb [1024];

  always @(posedge clk) begin
    if (sram_re_A) sram_rdata_A <= mem_a_tb[sram_addr_A];
    if (sram_re_B) sram_rdata_B <= mem_b_tb[sram_addr_B];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: ordered queue of expected pairs with the cycle they become visible.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          rdy;
  } exp_t;

  exp_t q[$];
  int   m_out = 0;
  logic m_err = 1'b0;
  logic m_drain = 1'b0;
  int   m_start = 0;
  int   m_done_cyc = -1;

  function automatic logic [31:0] ref_align(input dtype_t dt, input logic sel, input logic [31:0] w);
    if (dt == FP16) return sel ? {16'h0000, w[31:16]} : {16'h0000, w[15:0]};
    return w;
  endfunction

  logic        s_rr, s_re, s_valid, s_done, s_err;
  logic [31:0] s_addr_a, s_addr_b, s_a, s_b;

  task automatic check_cycle();
    logic run, e_rr, e_acc, e_vld, e_done;
    exp_t e;
    s_rr = req_ready; s_re = sram_re_A; s_valid = op_valid; s_done = done; s_err = err;
    s_addr_a = 32'(sram_addr_A); s_addr_b = 32'(sram_addr_B); s_a = op_a; s_b = op_b;
    if (m_drain && m_done_cyc >= 0 && cyc > m_done_cyc) begin
      m_drain = 1'b0;
      m_done_cyc = -1;
    end
    if (rst) begin
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_sram_re", sram_re_A | sram_re_B, 1'b0);
      chk32("rst_sram_addr", {12'h0, sram_addr_A, sram_addr_B}, 32'h0);
      chk1("rst_op_valid", op_valid, 1'b0);
      chk32("rst_op_a", op_a | op_b, 32'h0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      q.delete();
      m_out = 0; m_err = 1'b0; m_drain = 1'b0; m_done_cyc = -1;
      return;
    end
    run    = !(m_drain && cyc > m_start);
    e_rr   = (m_out < DEPTH);
    e_acc  = en_in && e_rr && run;
    e_vld  = (q.size() > 0) && (q[0].rdy <= cyc);
    e_done = m_drain && (cyc == m_done_cyc);
    chk1("req_ready", req_ready, e_rr);
    chk1("sram_re_A", sram_re_A, e_acc);
    chk1("sram_re_B", sram_re_B, e_acc);
    if (e_acc) begin
      chk32("sram_addr_A", 32'(sram_addr_A), 32'(rdaddr_A[10:1]));
      chk32("sram_addr_B", 32'(sram_addr_B), 32'(rdaddr_B[10:1]));
    end
    chk1("op_valid", op_valid, e_vld);
    if (e_vld) begin
      chk32("op_a", op_a, q[0].a);
      chk32("op_b", op_b, q[0].b);
    end
    chk1("done", done, e_done);
    chk1("err", err, m_err);
    if (e_vld && op_ready) begin
      void'(q.pop_front());
      m_out--;
    end
    if (e_acc) begin
      e.a   = ref_align(datatype, rdaddr_A[0], mem_a_tb[rdaddr_A[10:1]]);
      e.b   = ref_align(datatype, rdaddr_B[0], mem_b_tb[rdaddr_B[10:1]]);
      e.rdy = cyc + 2;
      q.push_back(e);
      m_out++;
    end
    if (en_in && !e_acc) m_err = 1'b1;
    if (cm_in && run && !m_drain) begin
      m_drain = 1'b1;
      m_start = cyc;
    end
    if (m_drain && m_done_cyc < 0 && cyc > m_start && m_out == 0) m_done_cyc = cyc + 1;
  endtask

  task automatic step();
    #1;
    check_cycle();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1'b0; en_in = 1'b0; cm_in = 1'b0;
  endtask

  typedef struct {
    dtype_t      dt;
    logic [31:0] ad_a, ad_b, w_a, w_b, ex_a, ex_b;
  } vec_t;

  vec_t vt [7];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, first_v, np, nacc, nd, last_pop, done_at;
    logic got;
    logic [31:0] pop_val;

    vt[0] = '{FP32, 32'd2, 32'd4, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0};
    vt[1] = '{FP16, 32'd5, 32'd4, 32'hBEEF_CAFE, 32'hBEEF_CAFE, 32'h0000_BEEF, 32'h0000_CAFE};
    vt[2] = '{FP16, 32'd4, 32'd5, 32'hBEEF_CAFE, 32'h0123_4567, 32'h0000_CAFE, 32'h0000_0123};
    vt[3] = '{FP16, 32'd9, 32'd8, 32'hDEAD_BEEF, 32'h0123_4567, 32'h0000_DEAD, 32'h0000_4567};
    vt[4] = '{INT8, 32'd3, 32'd6, 32'hA5A5_0F0F, 32'h8001_7FFE, 32'hA5A5_0F0F, 32'h8001_7FFE};
    vt[5] = '{INT4, 32'd7, 32'd11, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_FFFF};
    vt[6] = '{FP32, 32'd1, 32'd1, 32'hCAFE_F00D, 32'h1357_9BDF, 32'hCAFE_F00D, 32'h1357_9BDF};

    for (int i = 0; i < 1024; i++) begin
      mem_a_tb[i] = $urandom();
      mem_b_tb[i] = $urandom();
    end
    rst = 1'b1; en_in = 1'b0; cm_in = 1'b0; op_ready = 1'b0; datatype = FP32;
    rdaddr_A = '0; rdaddr_B = '0;
    @(negedge clk);

    // Reset state
    step();
    chk1("reset_req_ready", s_rr, 1'b0);
    chk1("reset_op_valid", s_valid, 1'b0);
    set_idle();
    step();
    chk1("post_reset_req_ready", s_rr, 1'b1);
    chk1("post_reset_err", s_err, 1'b0);

    // Back-to-back FP32 stream
    op_ready = 1'b1; datatype = FP32;
    c0 = cyc; first_v = -1; np = 0;
    for (int i = 0; i < 14; i++) begin
      en_in = (i < 8);
      rdaddr_A = 32'(2 * i);
      rdaddr_B = 32'(2 * (i + 100));
      step();
      if (i < 8) begin
        chk1("t1_re", s_re, 1'b1);
        chk32("t1_addr_A", s_addr_a, 32'(i));
        chk32("t1_addr_B", s_addr_b, 32'(i + 100));
      end
      if (s_valid && first_v < 0) first_v = cyc - 1 - c0;
      if (s_valid) np++;
    end
    chk32("t1_first_valid_latency", 32'(first_v), 32'd2);
    chk32("t1_pairs_out", 32'(np), 32'd8);

    // Alignment vector table
    for (int v = 0; v < 7; v++) begin
      mem_a_tb[vt[v].ad_a[10:1]] = vt[v].w_a;
      mem_b_tb[vt[v].ad_b[10:1]] = vt[v].w_b;
      datatype = vt[v].dt; rdaddr_A = vt[v].ad_a; rdaddr_B = vt[v].ad_b;
      en_in = 1'b1;
      step();
      en_in = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 6 && !got; t++) begin
        step();
        if (s_valid) begin
          got = 1'b1;
          chk32($sformatf("tbl%0d_op_a", v), s_a, vt[v].ex_a);
          chk32($sformatf("tbl%0d_op_b", v), s_b, vt[v].ex_b);
        end
      end
      chk1($sformatf("tbl%0d_valid_seen", v), got, 1'b1);
    end

    // Credit back-pressure: 6 requests against a stalled array
    op_ready = 1'b0; datatype = FP32; nacc = 0;
    for (int i = 0; i < 6; i++) begin
      en_in = 1'b1; rdaddr_A = 32'(40 + 2 * i); rdaddr_B = 32'(80 + 2 * i);
      step();
      if (s_re) nacc++;
      if (i == 4) chk1("t3_req_ready_5th", s_rr, 1'b0);
    end
    en_in = 1'b0;
    step();
    chk32("t3_accepts", 32'(nacc), 32'd4);
    chk1("t3_err_set", s_err, 1'b1);
    op_ready = 1'b1; np = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_valid) np++;
    end
    chk32("t3_pairs_out", 32'(np), 32'd4);

    // Drain with toggling ready
    rst = 1'b1; step(); set_idle();
    op_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en_in = 1'b1; rdaddr_A = 32'(200 + 2 * i); rdaddr_B = 32'(300 + 2 * i);
      step();
    end
    en_in = 1'b0; cm_in = 1'b1;
    step();
    cm_in = 1'b0;
    np = 0; nd = 0; last_pop = -1; done_at = -1;
    for (int i = 0; i < 16; i++) begin
      op_ready = (i % 2 == 0);
      en_in = (i == 1);
      step();
      if (s_valid && op_ready) begin np++; last_pop = cyc - 1; end
      if (s_done) begin nd++; done_at = cyc - 1; end
    end
    en_in = 1'b0;
    chk32("t4_pops", 32'(np), 32'd3);
    chk32("t4_done_pulses", 32'(nd), 32'd1);
    chk32("t4_done_after_last_pop", 32'(done_at), 32'(last_pop + 1));
    chk1("t4_err_en_in_drain", s_err, 1'b1);

    // Reset with reads in flight
    op_ready = 1'b0; datatype = FP32;
    for (int i = 0; i < 2; i++) begin
      en_in = 1'b1; rdaddr_A = 32'(20 + 2 * i); rdaddr_B = 32'(22 + 2 * i);
      step();
    end
    rst = 1'b1; en_in = 1'b1;
    step();
    chk1("t5_rst_req_ready", s_rr, 1'b0);
    chk1("t5_rst_sram_re", s_re, 1'b0);
    chk1("t5_rst_op_valid", s_valid, 1'b0);
    chk32("t5_rst_op_a", s_a, 32'h0);
    chk1("t5_rst_done", s_done, 1'b0);
    chk1("t5_rst_err", s_err, 1'b0);
    set_idle();
    step();
    mem_a_tb[15] = 32'h5555_AAAA; mem_b_tb[16] = 32'h0F0F_F0F0;
    en_in = 1'b1; rdaddr_A = 32'd30; rdaddr_B = 32'd32;
    step();
    en_in = 1'b0; op_ready = 1'b1; np = 0; pop_val = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_valid) begin np++; pop_val = s_a; end
    end
    chk32("t5_pairs_out", 32'(np), 32'd1);
    chk32("t5_post_reset_op_a", pop_val, 32'h5555_AAAA);

    // Randomized traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      en_in    = ($urandom_range(0, 1) == 1);
      cm_in    = ($urandom_range(0, 24) == 0);
      op_ready = ($urandom_range(0, 9) < 6);
      datatype = dtype_t'($urandom_range(0, 3));
      rdaddr_A = $urandom();
      rdaddr_B = $urandom();
      step();
    end
    set_idle(); op_ready = 1'b1;
    repeat (12) step();

`ifdef OPF_PERF_EN
    // Stall counter
    rst = 1'b1; step(); set_idle();
    op_ready = 1'b0; en_in = 1'b1; rdaddr_A = 32'd50; rdaddr_B = 32'd52;
    step();
    en_in = 1'b0;
    step();
    repeat (10) step();
    #1;
    chk32("t6_stall_cnt", stall_cnt, 32'd10);
    op_ready = 1'b1;
    repeat (3) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
